// File: rtl/lsu_mem_master.sv
// Load/store unit acting as data-memory initiator on a request/grant/response bus.
// One access in flight; word-crossing accesses become two bus transfers.
// Load data is lane-aligned and sign/zero-extended according to funct3.
module lsu_mem_master #(
    parameter logic [31:0] ADDR_BASE  = 32'h8000_0000,
    parameter logic [31:0] ADDR_LIMIT = 32'h8000_FFFF
) (
    input  logic        CLK,
    input  logic        RST_N,
    // core request side
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_funct3_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    // core response side
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    // memory bus
    output logic        mem_req_o,
    input  logic        mem_gnt_i,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [3:0]  mem_be_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ0,
        S_WAIT0,
        S_REQ1,
        S_WAIT1,
        S_RESP
    } state_t;

    state_t      r_state;

    // latched request
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [3:0]  r_be_hi;
    logic [31:0] r_wdata_hi;
    logic [31:0] r_rdata0;

    // registered outputs
    logic        r_rsp_valid;
    logic [31:0] r_rsp_rdata;
    logic        r_rsp_err;
    logic        r_mem_req;
    logic [31:0] r_mem_addr;
    logic        r_mem_we;
    logic [3:0]  r_mem_be;
    logic [31:0] r_mem_wdata;

    // request decode
    logic [1:0]  w_size_m1;
    logic [3:0]  w_size_mask;
    logic [32:0] w_last_byte;
    logic        w_range_err;
    logic        w_funct3_err;
    logic        w_req_err;
    logic [7:0]  w_req_be8;
    logic [63:0] w_req_wdata64;

    // load data path
    logic [63:0] w_rd64;
    logic [31:0] w_shifted;
    logic [31:0] w_load;
    logic        w_split;

    // Decode size, legality and lane placement of the incoming request
    always_comb begin
        w_size_m1   = 2'd3;
        w_size_mask = 4'b1111;
        case (req_funct3_i[1:0])
            2'b00: begin
                w_size_m1   = 2'd0;
                w_size_mask = 4'b0001;
            end
            2'b01: begin
                w_size_m1   = 2'd1;
                w_size_mask = 4'b0011;
            end
            default: begin
                w_size_m1   = 2'd3;
                w_size_mask = 4'b1111;
            end
        endcase
        // 33-bit end address so a wrap past 2^32 lands above the limit
        w_last_byte   = {1'b0, req_addr_i} + 33'(w_size_m1);
        w_range_err   = (req_addr_i < ADDR_BASE) || (w_last_byte > {1'b0, ADDR_LIMIT});
        w_funct3_err  = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                        (req_we_i && req_funct3_i[2]);
        w_req_err     = w_range_err || w_funct3_err;
        w_req_be8     = {4'b0000, w_size_mask} << req_addr_i[1:0];
        w_req_wdata64 = {32'h0000_0000, req_wdata_i} << {req_addr_i[1:0], 3'b000};
    end

    // Align returned word(s) to the accessed byte and extend per funct3
    always_comb begin
        w_rd64    = (r_state == S_WAIT1) ? {mem_rdata_i, r_rdata0} : {32'h0000_0000, mem_rdata_i};
        w_shifted = 32'(w_rd64 >> {r_addr[1:0], 3'b000});
        w_split   = |r_be_hi;
        w_load    = '0;
        case (r_funct3)
            3'b000:  w_load = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_load = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load = w_shifted;
            3'b100:  w_load = {24'h00_0000, w_shifted[7:0]};
            3'b101:  w_load = {16'h0000, w_shifted[15:0]};
            default: w_load = '0;
        endcase
    end

    // Access sequencer: accept, issue one or two bus beats, respond
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state     <= S_IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_be_hi     <= '0;
            r_wdata_hi  <= '0;
            r_rdata0    <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_we       <= req_we_i;
                        r_funct3   <= req_funct3_i;
                        r_addr     <= req_addr_i;
                        r_be_hi    <= w_req_be8[7:4];
                        r_wdata_hi <= w_req_wdata64[63:32];
                        if (w_req_err) begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b1;
                            r_rsp_rdata <= '0;
                        end else begin
                            r_state     <= S_REQ0;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {req_addr_i[31:2], 2'b00};
                            r_mem_we    <= req_we_i;
                            r_mem_be    <= w_req_be8[3:0];
                            r_mem_wdata <= w_req_wdata64[31:0];
                        end
                    end
                end
                S_REQ0: begin
                    if (mem_gnt_i) begin
                        r_state     <= S_WAIT0;
                        r_mem_req   <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                S_WAIT0: begin
                    if (mem_rvalid_i) begin
                        r_rdata0 <= mem_rdata_i;
                        if (w_split) begin
                            r_state     <= S_REQ1;
                            r_mem_req   <= 1'b1;
                            r_mem_addr  <= {r_addr[31:2] + 30'd1, 2'b00};
                            r_mem_we    <= r_we;
                            r_mem_be    <= r_be_hi;
                            r_mem_wdata <= r_wdata_hi;
                        end else begin
                            r_state     <= S_RESP;
                            r_rsp_valid <= 1'b1;
                            r_rsp_err   <= 1'b0;
                            r_rsp_rdata <= r_we ? '0 : w_load;
                        end
                    end
                end
                S_REQ1: begin
                    if (mem_gnt_i) begin
                        r_state     <= S_WAIT1;
                        r_mem_req   <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_we    <= 1'b0;
                        r_mem_be    <= '0;
                        r_mem_wdata <= '0;
                    end
                end
                S_WAIT1: begin
                    if (mem_rvalid_i) begin
                        r_state     <= S_RESP;
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= 1'b0;
                        r_rsp_rdata <= r_we ? '0 : w_load;
                    end
                end
                S_RESP: begin
                    r_state     <= S_IDLE;
                    r_rsp_valid <= 1'b0;
                    r_rsp_err   <= 1'b0;
                    r_rsp_rdata <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign rsp_valid_o = r_rsp_valid;
    assign rsp_rdata_o = r_rsp_rdata;
    assign rsp_err_o   = r_rsp_err;
    assign mem_req_o   = r_mem_req;
    assign mem_addr_o  = r_mem_addr;
    assign mem_we_o    = r_mem_we;
    assign mem_be_o    = r_mem_be;
    assign mem_wdata_o = r_mem_wdata;

endmodule

// File: doc/lsu_mem_master.md
# lsu_mem_master

Load/store unit that issues single-cycle-core load and store requests onto the data-memory request/grant/response bus and returns load data to the core. Sits between the core's execute stage and the data memory, acting as the memory initiator. It holds at most one access in flight. It generates byte enables and aligns write data by lane. It splits word-crossing accesses into two bus transfers, and aligns and sign- or zero-extends returned load data per funct3.

## Interface
- ADDR_BASE, 32'h8000_0000, lowest legal byte address
- ADDR_LIMIT, 32'h8000_FFFF, highest legal byte address
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- req_valid_i  in  1  core request valid
- req_ready_o  out  1  unit can accept request (state IDLE)
- req_we_i  in  1  1 = store, 0 = load
- req_funct3_i  in  3  000 b, 001 h, 010 w, 100 bu, 101 hu
- req_addr_i  in  32  byte address
- req_wdata_i  in  32  store data, LSB-justified
- rsp_valid_o  out  1  one-cycle response pulse
- rsp_rdata_o  out  32  extended load data (0 for stores and errors)
- rsp_err_o  out  1  access fault, qualified by rsp_valid_o
- mem_req_o  out  1  bus request, held until granted
- mem_gnt_i  in  1  bus grant
- mem_addr_o  out  32  word-aligned byte address, [1:0]=00
- mem_we_o  out  1  write strobe
- mem_be_o  out  4  byte enables
- mem_wdata_o  out  32  lane-aligned write data
- mem_rvalid_i  in  1  transfer completion (reads and writes)
- mem_rdata_i  in  32  read word, valid with mem_rvalid_i

## Operation
- States: IDLE, REQ0, WAIT0, REQ1, WAIT1, RESP.
- IDLE: req_ready_o=1.
  - On req_valid_i, latch we, funct3, addr, wdata.
  - Illegal request → RESP with err.
    - Illegal funct3: 011, 110, 111.
    - Illegal store funct3: 1xx.
    - Out of range: any touched byte outside [ADDR_BASE, ADDR_LIMIT].
  - Otherwise → REQ0.
- size = 1/2/4 bytes; off = addr[1:0]; split = off+size > 4.
- REQ0: mem_req_o=1, mem_addr_o={addr[31:2],2'b00}.
  - mem_be_o = (size mask << off)[3:0]; mem_wdata_o = wdata << 8*off.
  - Signals stable until mem_gnt_i, then → WAIT0.
- WAIT0: on mem_rvalid_i, latch rdata0 → REQ1 if split, else RESP.
- REQ1: mem_addr_o = word address + 4.
  - mem_be_o = (size mask << off)[7:4]; mem_wdata_o = (wdata << 8*off)[63:32].
  - On mem_gnt_i → WAIT1.
- WAIT1: on mem_rvalid_i, latch rdata1 → RESP.
- Load data = ({rdata1, rdata0} >> 8*off) truncated to size.
  - b/h sign-extend from bit 7/15; bu/hu zero-extend.
- RESP: rsp_valid_o=1 for exactly one cycle → IDLE.
- Arithmetic: range check uses addr+size-1 in 33 bits; a wrap past 2^32 is a fault.
- mem_rvalid_i outside WAIT0/WAIT1 is ignored.
- mem_gnt_i while mem_req_o=0 is ignored.

## Timing
- Reset values:
  - state IDLE; req_ready_o=1.
  - rsp_valid_o=0, rsp_rdata_o=0, rsp_err_o=0.
  - mem_req_o=0, mem_we_o=0, mem_be_o=0, mem_addr_o=0, mem_wdata_o=0.
- Aligned access, gnt immediate, rvalid one cycle after gnt:
  - accept at cycle 0, mem_req_o at cycle 1, rvalid at cycle 2, rsp_valid_o at cycle 3 (latency 3).
- Split access adds 2 cycles minimum (latency 5).
- Fault: rsp_valid_o in the cycle after acceptance (latency 1); no bus activity.
- Each extra gnt or rvalid wait cycle adds one cycle of latency.
- mem_rvalid_i may arrive no earlier than the cycle after gnt.
- Back-to-back: a new request is accepted the cycle after RESP, so the request rate is at most 1 per 4 cycles.
- mem_req_o, mem_addr_o, mem_be_o, mem_we_o and mem_wdata_o are registered.
- Reset mid-access:
  - mem_req_o deasserts immediately.
  - No response is produced.
  - A late mem_rvalid_i is dropped in IDLE.

## Test plan
- Aligned lw from 0x8000_0010, memory returns 0xDEADBEEF.
  - Expect be=1111, rsp_rdata_o=0xDEADBEEF, latency 3.
- lb from 0x8000_0013, word 0x80FF_0000.
  - Expect be=1000, rsp_rdata_o=0xFFFF_FF80.
  - Same access with lbu: expect 0x0000_0080.
- Split sw 0x1122_3344 to 0x8000_0006.
  - Expect beat 1: addr 0x8000_0004, be=1100, wdata 0x3344_0000.
  - Expect beat 2: addr 0x8000_0008, be=0011, wdata 0x0000_1122.
  - Expect rsp_err_o=0.
- Split lh from 0x8000_0007, words 0xAB00_0000 then 0x0000_00CD.
  - Expect rsp_rdata_o=0xFFFF_CDAB.
- Faults:
  - lw at 0x8000_FFFE → rsp_err_o=1, mem_req_o never asserted, latency 1.
  - funct3=011 → same response.
  - sb at 0x7FFF_FFFF → same response.
- Stall and reset:
  - Hold mem_gnt_i low 5 cycles: mem_req_o and mem_addr_o stay stable.
  - Assert RST_N=0 in WAIT0: all outputs return to reset values; a following rvalid is ignored.
